alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Sequencing front-end for the 2-bit ALU. It accepts ALU commands (A, B, Cin, 3-bit opcode) over a valid/ready handshake and buffers them in a 4-entry FIFO. It issues them one at a time to the combinational ALU on registered operand lines, captures the 4-bit ALU result, and presents it downstream over a second valid/ready handshake. It sits directly upstream of the ALU, driving its A/B/Cin/S inputs and consuming its Y output.

## Interface
Parameters:
- FIFO_DEPTH, 4 — command buffer entries; power of two, minimum 2.
- CNT_W, 8 — width of the completed-operation counter.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- cmd_valid  in  1  — command present.
- cmd_ready  out  1  — FIFO can accept a command; equals !full.
- cmd_a  in  2  — operand A.
- cmd_b  in  2  — operand B.
- cmd_cin  in  1  — carry-in.
- cmd_op  in  3  — ALU opcode: 000 AND, 001 OR, 010 XOR, 011 NOT, 100 ADD, 101 SUB, 110 MUL, 111 A>B.
- alu_a  out  2  — registered operand to ALU A.
- alu_b  out  2  — registered operand to ALU B.
- alu_cin  out  1  — registered carry-in to ALU Cin.
- alu_s  out  3  — registered opcode to ALU S.
- alu_y  in  4  — ALU result (combinational from alu_*).
- res_valid  out  1  — result register holds an unconsumed result.
- res_ready  in  1  — downstream accepts the result.
- res_y  out  4  — captured result.
- res_op  out  3 — opcode that produced res_y.
- ops_done  out  CNT_W  — count of completed result handshakes; wraps.

## Operation
- Push: the FIFO writes a command when cmd_valid && cmd_ready at the edge.
- Pop: the FIFO pops when leaving ISSUE. Push and pop in the same cycle are both honoured.
- A full FIFO never accepts a command, because cmd_ready is low.
- FSM states:
  - IDLE: if the FIFO is non-empty, load alu_* from the FIFO head and go to ISSUE. Otherwise stay.
  - ISSUE: alu_* are held stable for one full cycle. At the edge, capture alu_y into res_y and alu_s into res_op, set res_valid=1, pop the FIFO, and go to HOLD.
  - HOLD: res_valid=1 and res_y/res_op are frozen until res_ready. On a handshake, increment ops_done (wrapping at 2^CNT_W−1 → 0), then:
    - if the FIFO is non-empty, load alu_* from the new head and go to ISSUE, with res_valid cleared;
    - otherwise clear res_valid and go to IDLE.
- alu_* change only on the load edge. They hold their last value in IDLE and HOLD.
- No opcode is illegal. The sequencer never interprets alu_y.

## Timing
- Reset values:
  - state = IDLE; FIFO empty (pointers 0).
  - cmd_ready=1, res_valid=0, res_y=0, res_op=0.
  - alu_a=0, alu_b=0, alu_cin=0, alu_s=000.
  - ops_done=0.
- Latency into an empty, idle block:
  - accept at edge E0 → alu_* loaded at E1 → res_valid=1 after E2 (2 cycles).
- Throughput: one result per 2 cycles when res_ready is held high (ISSUE, HOLD, ISSUE, …).
- res_valid must never drop without a handshake. res_y and res_op must not change while res_valid=1 and res_ready=0.
- cmd_ready deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop.
- Reset mid-operation discards all buffered commands and any pending result. There is no partial handshake after reset.

## Structure
- Shared package alu_seq_pkg:
  - opcode localparams (OP_AND … OP_GT);
  - FSM state encoding (ST_IDLE, ST_ISSUE, ST_HOLD);
  - packed command width (8 bits: op, cin, b, a).
- Sub-module sync_fifo: parameterised width/depth, synchronous active-high reset, with push/pop/full/empty/head outputs.
- Top-level content: FSM, alu_* registers, result register and counter.

## Test plan
- Single MUL, A=3 B=3 Cin=0 op=110, res_ready=1, real ALU attached → res_y=1001, res_op=110, 2 cycles after accept; ops_done=1.
- Back-to-back AND (A=3 B=1 → 0001) then A>B (A=2 B=1 → 0001) with res_ready=1 → results in order, 2 cycles apart; ops_done=2.
- Backpressure: res_ready=0, push 5 commands → 4 buffered plus 1 in HOLD. cmd_ready=0 after the 4th buffered push; res_y stays stable. Release res_ready → all 5 results emerge in order.
- Simultaneous push and pop at FIFO count 2 → count unchanged, no command lost or duplicated.
- Counter wrap: 256 completed handshakes → ops_done returns to 0.
- Assert rst while in HOLD with 3 commands queued → next cycle res_valid=0, cmd_ready=1, alu_*=0, state IDLE; no further results emerge.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
// Opcode values, FSM state encoding and the packed command layout.
// Imported by the sequencer top and the testbench.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_GT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Packed command as stored in the FIFO: op in the MSBs, A in the LSBs.
  localparam int CMD_W = 8;

  typedef struct packed {
    logic [2:0] op;
    logic       cin;
    logic [1:0] b;
    logic [1:0] a;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
// Carries the command handshake, the ALU operand/result lines and the result handshake.
// slave = sequencer view, master = environment (command source, ALU, result sink).
interface alu_cmd_sequencer_if #(
  parameter int CNT_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_a;
  logic [1:0]       cmd_b;
  logic             cmd_cin;
  logic [2:0]       cmd_op;

  logic [1:0]       alu_a;
  logic [1:0]       alu_b;
  logic             alu_cin;
  logic [2:0]       alu_s;
  logic [3:0]       alu_y;

  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_y;
  logic [2:0]       res_op;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_cin, alu_s,
    input  alu_y,
    output res_valid, res_y, res_op, ops_done,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_cin, alu_s,
    output alu_y,
    input  res_valid, res_y, res_op, ops_done,
    output res_ready
  );

endinterface

// File: rtl/alu_cmd_sequencer_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; DEPTH must be a power of two.
// Latency: a pushed word is visible at head_o the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time on registered operand lines, returns results.
// Latency: accept at E0 -> operands loaded at E1 -> result valid after E2; one result per 2 cycles.
// Backpressure: cmd_ready = FIFO not full; result held frozen until res_ready.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus
);

  state_e           state_q;
  cmd_t             alu_q;
  logic             res_valid_q;
  logic [3:0]       res_y_q;
  logic [2:0]       res_op_q;
  logic [CNT_W-1:0] ops_done_q;

  cmd_t             cmd_in;
  logic [CMD_W-1:0] fifo_head;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign cmd_in    = {bus.cmd_op, bus.cmd_cin, bus.cmd_b, bus.cmd_a};
  assign head      = cmd_t'(fifo_head);
  assign fifo_push = bus.cmd_valid && !fifo_full;
  // The issued command stays in the FIFO until its result is captured.
  assign fifo_pop  = (state_q == ST_ISSUE);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (cmd_in),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue FSM with registered ALU operands, result register and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_q       <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_op_q    <= '0;
      ops_done_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_q   <= head;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Operands have been stable for a full cycle; ALU output is settled.
          res_y_q     <= bus.alu_y;
          res_op_q    <= alu_q.op;
          res_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            ops_done_q  <= ops_done_q + CNT_W'(1);
            res_valid_q <= 1'b0;
            if (!fifo_empty) begin
              alu_q   <= head;
              state_q <= ST_ISSUE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.alu_a     = alu_q.a;
  assign bus.alu_b     = alu_q.b;
  assign bus.alu_cin   = alu_q.cin;
  assign bus.alu_s     = alu_q.op;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_op    = res_op_q;
  assign bus.ops_done  = ops_done_q;

endmodule
